// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage LEGv8 core: load-use stalls,
// taken-branch flushes, data-memory freeze with sticky timeout, and statistics counters.
module hazard_stall_ctrl #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [31:0]      ID_Instr,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rd,
    input  logic             MEM_Access,
    input  logic             DMemReady,
    input  logic             MEM_BranchTaken,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Flush,
    output logic             PipeFreeze,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FREEZE  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_timeout;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic [10:0] w_op;
    logic [4:0]  w_rn;
    logic [4:0]  w_rm;
    logic [4:0]  w_rt;
    logic        w_reads_rn;
    logic        w_reads_rm;
    logic        w_reads_rt;
    logic        w_loaduse;
    logic        w_freeze;
    logic        w_branch;
    logic        w_lu_stall;

    assign w_op = ID_Instr[31:21];
    assign w_rn = ID_Instr[9:5];
    assign w_rm = ID_Instr[20:16];
    assign w_rt = ID_Instr[4:0];

    // Which register fields the IF/ID instruction actually reads; decode order matters.
    always_comb begin
        w_reads_rn = 1'b1;
        w_reads_rm = 1'b1;
        w_reads_rt = 1'b0;
        if (ID_Instr[31:24] == 8'b10110100 || ID_Instr[31:24] == 8'b10110101) begin
            w_reads_rn = 1'b0;
            w_reads_rm = 1'b0;
            w_reads_rt = 1'b1;
        end else if (ID_Instr[31:26] == 6'b000101 || ID_Instr[31:26] == 6'b100101) begin
            w_reads_rn = 1'b0;
            w_reads_rm = 1'b0;
        end else if (w_op == 11'b11111000000) begin
            w_reads_rm = 1'b0;
            w_reads_rt = 1'b1;
        end else if (w_op == 11'b11111000010 || w_op == 11'b11010011011) begin
            w_reads_rm = 1'b0;
        end else if (ID_Instr[31:22] == 10'b1001000100 || ID_Instr[31:22] == 10'b1101000100 ||
                     ID_Instr[31:22] == 10'b1001001000 || ID_Instr[31:22] == 10'b1011001000) begin
            w_reads_rm = 1'b0;
        end
    end

    // EX_Rd != 31 already excludes XZR matches on every source field.
    assign w_loaduse = EX_MemRead && (EX_Rd != 5'd31) &&
                       ((w_reads_rn && (w_rn == EX_Rd)) ||
                        (w_reads_rm && (w_rm == EX_Rd)) ||
                        (w_reads_rt && (w_rt == EX_Rd)));

    assign w_freeze = ((r_state == ST_RUN) && MEM_Access && !DMemReady) ||
                      ((r_state == ST_FREEZE) && !DMemReady) ||
                      (r_state == ST_TIMEOUT);

    assign w_branch   = !w_freeze && MEM_BranchTaken;
    assign w_lu_stall = !w_freeze && !MEM_BranchTaken && w_loaduse;

    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        EXMEM_Flush = 1'b0;
        PipeFreeze  = 1'b0;
        if (Reset) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
            EXMEM_Flush = 1'b1;
        end else if (w_freeze) begin
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            PipeFreeze = 1'b1;
        end else if (w_branch) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
            EXMEM_Flush = 1'b1;
        end else if (w_lu_stall) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (MEM_Access && !DMemReady) begin
                        r_state    <= ST_FREEZE;
                        r_wait_cnt <= WAIT_W'(1);
                    end
                end
                ST_FREEZE: begin
                    if (DMemReady) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WAIT_W'(MAX_WAIT)) begin
                        r_state       <= ST_TIMEOUT;
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                ST_TIMEOUT: r_state <= ST_TIMEOUT;
                default:    r_state <= ST_RUN;
            endcase
            if ((w_freeze || w_lu_stall) && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_branch && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign MemTimeout  = r_mem_timeout;
    assign StallCycles = r_stall_cnt;
    assign FlushCount  = r_flush_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: the driver pushes expected outputs per cycle,
// the negedge monitor pops and compares them.
module tb_hazard_stall_ctrl;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;

    localparam logic [5:0] C_NORM   = 6'b110000;
    localparam logic [5:0] C_LU     = 6'b000100;
    localparam logic [5:0] C_BRANCH = 6'b111110;
    localparam logic [5:0] C_FREEZE = 6'b000001;
    localparam logic [5:0] C_RESET  = 6'b001110;

    logic             CLK = 1'b0;
    logic             Reset;
    logic [31:0]      ID_Instr;
    logic             EX_MemRead;
    logic [4:0]       EX_Rd;
    logic             MEM_Access;
    logic             DMemReady;
    logic             MEM_BranchTaken;
    logic             PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Flush, PipeFreeze;
    logic             MemTimeout;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] FlushCount;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [14:0] exp_q[$];
    string       tag_q[$];

    logic [CNT_W-1:0] m_st;
    logic [CNT_W-1:0] m_fl;

    hazard_stall_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
        .CLK(CLK), .Reset(Reset), .ID_Instr(ID_Instr), .EX_MemRead(EX_MemRead),
        .EX_Rd(EX_Rd), .MEM_Access(MEM_Access), .DMemReady(DMemReady),
        .MEM_BranchTaken(MEM_BranchTaken), .PCWrite(PCWrite), .IFID_Write(IFID_Write),
        .IFID_Flush(IFID_Flush), .IDEX_Bubble(IDEX_Bubble), .EXMEM_Flush(EXMEM_Flush),
        .PipeFreeze(PipeFreeze), .MemTimeout(MemTimeout), .StallCycles(StallCycles),
        .FlushCount(FlushCount), .o_dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        return {11'b10001011000, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] enc_ldur(input logic [4:0] rt, input logic [4:0] rn);
        return {11'b11111000010, 9'd0, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] enc_stur(input logic [4:0] rt, input logic [4:0] rn);
        return {11'b11111000000, 9'd0, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rn, input logic [11:0] imm);
        return {10'b1001000100, imm, rn, rd};
    endfunction
    function automatic logic [31:0] enc_cbz(input logic [4:0] rt, input logic [18:0] imm);
        return {8'b10110100, imm, rt};
    endfunction

    // One cycle: drive inputs, push expected outputs, advance the counter model.
    task automatic step(input string tag, input logic rst, input logic [31:0] instr,
                        input logic mr, input logic [4:0] rd, input logic ma, input logic rdy,
                        input logic br, input logic [5:0] ctl, input logic mt);
        Reset = rst; ID_Instr = instr; EX_MemRead = mr; EX_Rd = rd;
        MEM_Access = ma; DMemReady = rdy; MEM_BranchTaken = br;
        exp_q.push_back({ctl, mt, m_st, m_fl});
        tag_q.push_back(tag);
        if (rst) begin
            m_st = '0;
            m_fl = '0;
        end else begin
            if ((ctl == C_FREEZE || ctl == C_LU) && m_st != {CNT_W{1'b1}}) m_st = m_st + 1'b1;
            if (ctl == C_BRANCH && m_fl != {CNT_W{1'b1}}) m_fl = m_fl + 1'b1;
        end
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            logic [14:0] e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq({t, ".ctl"},   {26'd0, PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Flush, PipeFreeze},
                     {26'd0, e[14:9]});
            check_eq({t, ".mto"},   {31'd0, MemTimeout}, {31'd0, e[8]});
            check_eq({t, ".stall"}, {28'd0, StallCycles}, {28'd0, e[7:4]});
            check_eq({t, ".flush"}, {28'd0, FlushCount}, {28'd0, e[3:0]});
        end
    end

    initial begin
        logic [31:0] add_x3;
        logic [4:0]  r;
        add_x3 = enc_add(5'd5, 5'd3, 5'd4);
        m_st = '0;
        m_fl = '0;
        Reset = 1'b1; ID_Instr = add_x3; EX_MemRead = 1'b0; EX_Rd = 5'd0;
        MEM_Access = 1'b0; DMemReady = 1'b1; MEM_BranchTaken = 1'b0;
        @(posedge CLK);
        #1;

        // Reset state and load-use decode
        step("rst",      1, add_x3, 0, 5'd0, 0, 1, 0, C_RESET, 0);
        step("lu",       0, add_x3, 1, 5'd3, 0, 1, 0, C_LU,    0);
        step("lu_drop",  0, add_x3, 0, 5'd3, 1, 1, 0, C_NORM,  0);
        step("lu_rm",    0, enc_add(5'd5, 5'd1, 5'd3), 1, 5'd3, 0, 1, 0, C_LU, 0);
        step("lu_rm2",   0, enc_add(5'd5, 5'd1, 5'd3), 0, 5'd3, 0, 1, 0, C_NORM, 0);
        step("lu_xzr",   0, enc_add(5'd5, 5'd31, 5'd31), 1, 5'd31, 0, 1, 0, C_NORM, 0);
        step("lu_b",     0, {6'b000101, 26'h63}, 1, 5'd3, 0, 1, 0, C_NORM, 0);
        step("lu_cb",    0, enc_cbz(5'd3, 19'd7), 1, 5'd3, 0, 1, 0, C_LU, 0);
        step("lu_cbrn",  0, enc_cbz(5'd3, 19'd7), 1, 5'd7, 0, 1, 0, C_NORM, 0);
        step("lu_ldrt",  0, enc_ldur(5'd3, 5'd7), 1, 5'd3, 0, 1, 0, C_NORM, 0);
        step("lu_ldrn",  0, enc_ldur(5'd3, 5'd7), 1, 5'd7, 0, 1, 0, C_LU, 0);
        step("lu_stur",  0, enc_stur(5'd3, 5'd7), 1, 5'd3, 0, 1, 0, C_LU, 0);
        step("lu_addi",  0, enc_addi(5'd5, 5'd9, 12'h0C0), 1, 5'd3, 0, 1, 0, C_NORM, 0);
        step("lu_addn",  0, enc_addi(5'd5, 5'd9, 12'h0C0), 1, 5'd9, 0, 1, 0, C_LU, 0);
        for (int i = 0; i < 4; i++) begin
            r = 5'($urandom_range(0, 30));
            step("lu_rnd",  0, enc_add(5'd2, r, 5'd31), 1, r, 0, 1, 0, C_LU, 0);
            step("lu_rndm", 0, enc_add(5'd2, 5'd31, r), 1, r, 0, 1, 0, C_LU, 0);
            step("lu_rndn", 0, enc_add(5'd2, 5'd31, r), 0, r, 0, 1, 0, C_NORM, 0);
        end

        // Branch flush beats load-use
        step("rst",      1, add_x3, 0, 5'd0, 0, 1, 0, C_RESET, 0);
        step("br_lu",    0, add_x3, 1, 5'd3, 0, 1, 1, C_BRANCH, 0);
        step("br_after", 0, add_x3, 0, 5'd3, 0, 1, 0, C_NORM, 0);

        // Memory wait: freeze masks branch and load-use, flush lands on release
        step("rst",      1, add_x3, 0, 5'd0, 0, 1, 0, C_RESET, 0);
        for (int i = 0; i < 3; i++)
            step("mw_frz", 0, add_x3, 1, 5'd3, 1, 0, 1, C_FREEZE, 0);
        step("mw_rel",   0, add_x3, 1, 5'd3, 1, 1, 1, C_BRANCH, 0);
        step("mw_after", 0, add_x3, 0, 5'd3, 0, 1, 0, C_NORM, 0);

        // Release on the last tolerated wait cycle does not time out
        step("rst",      1, add_x3, 0, 5'd0, 0, 1, 0, C_RESET, 0);
        for (int i = 0; i < MAX_WAIT; i++)
            step("edge_frz", 0, add_x3, 0, 5'd0, 1, 0, 0, C_FREEZE, 0);
        step("edge_rel", 0, add_x3, 0, 5'd0, 1, 1, 0, C_NORM, 0);
        step("edge_run", 0, add_x3, 0, 5'd0, 0, 1, 0, C_NORM, 0);

        // Timeout is sticky and keeps the pipeline frozen
        step("rst",      1, add_x3, 0, 5'd0, 0, 1, 0, C_RESET, 0);
        for (int i = 0; i <= MAX_WAIT; i++)
            step("to_frz", 0, add_x3, 0, 5'd0, 1, 0, 0, C_FREEZE, 0);
        step("to_set",   0, add_x3, 0, 5'd0, 1, 0, 0, C_FREEZE, 1);
        step("to_rdy",   0, add_x3, 1, 5'd3, 1, 1, 1, C_FREEZE, 1);
        step("to_idle",  0, add_x3, 0, 5'd0, 0, 1, 0, C_FREEZE, 1);

        // Reset from TIMEOUT
        step("to_rst",   1, add_x3, 0, 5'd0, 1, 0, 0, C_RESET, 1);
        step("post_rst", 0, add_x3, 0, 5'd0, 0, 1, 0, C_NORM, 0);

        // Stall counter saturation
        step("rst",      1, add_x3, 0, 5'd0, 0, 1, 0, C_RESET, 0);
        for (int i = 0; i < 20; i++)
            step("sat_lu", 0, add_x3, 1, 5'd3, 0, 1, 0, C_LU, 0);
        step("sat_hold", 0, add_x3, 0, 5'd3, 0, 1, 0, C_NORM, 0);

        @(negedge CLK);
        #1;
        check_eq("drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
